// File: rtl/vedic_mul_pipe.sv
// Pipelined unsigned Vedic (Urdhva-Tiryagbhyam) multiplier, s = a*b, with sideband tag.
// Latency: LAT = log2(WIDTH/LEAF) + 2 cycles; throughput one beat per cycle.
// Backpressure: global stall; when out_valid && !out_ready every stage holds and in_ready = 0.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready, a, b, in_tag   operand beat handshake
//   out_valid/out_ready, s, out_tag   product beat handshake
//   busy                          any stage holds a valid beat
module vedic_mul_pipe #(
    parameter int WIDTH = 64,
    parameter int LEAF  = 8,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   s,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int LVL = $clog2(WIDTH / LEAF);
    localparam int LAT = LVL + 2;
    localparam int M0  = WIDTH / LEAF;

    // One stall signal for the whole pipe: everything moves or nothing does.
    logic adv;
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    // Valid and tag for stages 1..LAT-1; the output stage has its own registers.
    logic [LAT-2:0]   vld;
    logic [TAG_W-1:0] tag_q [LAT-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (adv) begin
            for (int k = LAT - 2; k >= 1; k--)
                vld[k] <= vld[k-1];
            vld[0] <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = LAT - 2; k >= 1; k--)
                tag_q[k] <= tag_q[k-1];
            tag_q[0] <= in_tag;
        end
    end

    // Stage 1: every LEAF x LEAF partial product. Slot (i*M0+j) holds a_chunk[i] * b_chunk[j].
    logic [M0*M0*2*LEAF-1:0] leaf_q;

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < M0; i++)
                for (int j = 0; j < M0; j++)
                    leaf_q[(i*M0+j)*2*LEAF +: 2*LEAF] <=
                        {{LEAF{1'b0}}, a[i*LEAF +: LEAF]} * {{LEAF{1'b0}}, b[j*LEAF +: LEAF]};
        end
    end

    // Combine levels: level g merges 2x2 blocks of the previous level's products into
    // one product of (LEAF<<g)-bit operands. Slot (i,j) at this level draws from
    // slots (2i+{0,1}, 2j+{0,1}) of the level below; the odd index is the high half.
    for (genvar g = 1; g <= LVL; g++) begin : lv
        localparam int OW = LEAF << g;
        localparam int HW = OW / 2;
        localparam int M  = WIDTH / OW;
        localparam int MP = 2 * M;

        logic [MP*MP*OW-1:0]  prev;
        logic [M*M*2*OW-1:0]  nxt;
        logic [M*M*2*OW-1:0]  prod;

        if (g == 1) begin : src_leaf
            assign prev = leaf_q;
        end else begin : src_lvl
            assign prev = lv[g-1].prod;
        end

        // Middle term hl+lh is formed at OW+1 bits inside the concatenation so its carry survives.
        always_comb begin
            nxt = '0;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < M; j++)
                    nxt[(i*M+j)*2*OW +: 2*OW] =
                          {prev[((2*i+1)*MP + 2*j+1)*OW +: OW], {OW{1'b0}}}
                        + {{(HW-1){1'b0}},
                           ({1'b0, prev[((2*i+1)*MP + 2*j)*OW +: OW]}
                          + {1'b0, prev[((2*i)*MP + 2*j+1)*OW +: OW]}),
                           {HW{1'b0}}}
                        + {{OW{1'b0}}, prev[((2*i)*MP + 2*j)*OW +: OW]};
        end

        always_ff @(posedge clk) begin
            if (adv)
                prod <= nxt;
        end
    end

    logic [2*WIDTH-1:0] fin;

    if (LVL == 0) begin : fin_leaf
        assign fin = leaf_q;
    end else begin : fin_lvl
        assign fin = lv[LVL].prod;
    end

    // Output stage: the only data registers that are cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= vld[LAT-2];
            s         <= fin;
            out_tag   <= tag_q[LAT-2];
        end
    end

    assign busy = (|vld) || out_valid;

endmodule

// File: tb/tb_vedic_mul_pipe.sv
module tb_vedic_mul_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0: defaults 64/8 (LAT 5)
    logic         iv0, ir0, ov0, or0, busy0;
    logic [63:0]  a0, b0;
    logic [7:0]   it0, ot0;
    logic [127:0] s0;
    // Instance 1: 32/32 (LAT 2)
    logic         iv1, ir1, ov1, or1, busy1;
    logic [31:0]  a1, b1;
    logic [7:0]   it1, ot1;
    logic [63:0]  s1;
    // Instance 2: 128/16 (LAT 5)
    logic         iv2, ir2, ov2, or2, busy2;
    logic [127:0] a2, b2;
    logic [7:0]   it2, ot2;
    logic [255:0] s2;

    vedic_mul_pipe #(.WIDTH(64), .LEAF(8), .TAG_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .in_tag(it0),
        .out_valid(ov0), .out_ready(or0), .s(s0), .out_tag(ot0), .busy(busy0));
    vedic_mul_pipe #(.WIDTH(32), .LEAF(32), .TAG_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .in_tag(it1),
        .out_valid(ov1), .out_ready(or1), .s(s1), .out_tag(ot1), .busy(busy1));
    vedic_mul_pipe #(.WIDTH(128), .LEAF(16), .TAG_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .in_tag(it2),
        .out_valid(ov2), .out_ready(or2), .s(s2), .out_tag(ot2), .busy(busy2));

    task test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
        checks++; if (s0 !== 128'd0) begin errors++; $display("FAIL reset_s got %h want 0", s0); end
        checks++; if (ot0 !== 8'd0) begin errors++; $display("FAIL reset_out_tag got %h want 0", ot0); end
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir0); end
        checks++; if (ov1 !== 1'b0 || ov2 !== 1'b0) begin errors++; $display("FAIL reset_other_valid got %b%b want 00", ov1, ov2); end
        rst_n = 1'b1;
    endtask

    // Beat driven right after reference edge 0, captured at edge 1, visible after edge 5.
    task test_latency;
        @(posedge clk); #1;
        iv0 = 1'b1; a0 = 64'd3; b0 = 64'd5; it0 = 8'h11; or0 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            iv0 = 1'b0;
            checks++;
            if (ov0 !== (k == 5)) begin
                errors++; $display("FAIL latency_valid edge %0d got %b want %b", k, ov0, (k == 5));
            end
            if (k == 5) begin
                checks++; if (s0 !== 128'd15) begin errors++; $display("FAIL latency_s got %h want f", s0); end
                checks++; if (ot0 !== 8'h11) begin errors++; $display("FAIL latency_tag got %h want 11", ot0); end
            end
        end
    endtask

    task test_extremes;
        logic [63:0]  ea [3];
        logic [63:0]  eb [3];
        logic [127:0] es [3];
        int got, first, last;
        ea[0] = 64'hFFFF_FFFF_FFFF_FFFF; eb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        es[0] = {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001};
        ea[1] = 64'd0;                   eb[1] = 64'hFFFF_FFFF_FFFF_FFFF; es[1] = 128'd0;
        ea[2] = 64'h8000_0000_0000_0000; eb[2] = 64'd2;                   es[2] = {64'd1, 64'd0};
        got = 0; first = -1; last = -1;
        or0 = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 3) begin
                iv0 = 1'b1; a0 = ea[cyc]; b0 = eb[cyc]; it0 = 8'(8'h20 + cyc);
            end else begin
                iv0 = 1'b0;
            end
            #2;
            if (ov0) begin
                checks++;
                if (got >= 3) begin
                    errors++; $display("FAIL extremes_extra got output tag %h want none", ot0);
                end else if (s0 !== es[got] || ot0 !== 8'(8'h20 + got)) begin
                    errors++;
                    $display("FAIL extremes_%0d got s=%h tag=%h want s=%h tag=%h",
                             got, s0, ot0, es[got], 8'(8'h20 + got));
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
        end
        checks++; if (got != 3) begin errors++; $display("FAIL extremes_count got %0d want 3", got); end
        checks++; if (last - first != 2) begin errors++; $display("FAIL back_to_back span got %0d want 2", last - first); end
    endtask

    task test_backpressure;
        logic [127:0] q_s [$];
        logic [7:0]   q_t [$];
        logic [127:0] hs, es;
        logic [7:0]   ht, et;
        logic         hold, pend, exp_ir;
        int           sent, got;
        sent = 0; got = 0; hold = 1'b0; pend = 1'b0; hs = '0; ht = '0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            @(posedge clk); #1;
            if (!pend && sent < 20) begin
                a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; it0 = 8'(sent); pend = 1'b1;
            end
            iv0 = pend;
            or0 = 1'($urandom_range(0, 1));
            #2;
            if (hold) begin
                checks++;
                if (ov0 !== 1'b1 || s0 !== hs || ot0 !== ht) begin
                    errors++;
                    $display("FAIL bp_hold got v=%b s=%h tag=%h want v=1 s=%h tag=%h", ov0, s0, ot0, hs, ht);
                end
            end
            exp_ir = !(ov0 && !or0);
            checks++;
            if (ir0 !== exp_ir) begin errors++; $display("FAIL bp_in_ready got %b want %b", ir0, exp_ir); end
            if (iv0 && ir0) begin
                q_s.push_back({64'd0, a0} * {64'd0, b0});
                q_t.push_back(it0);
                sent++; pend = 1'b0;
            end
            if (ov0 && or0) begin
                checks++;
                if (q_s.size() == 0) begin
                    errors++; $display("FAIL bp_unexpected got tag %h want no output", ot0);
                end else begin
                    es = q_s.pop_front(); et = q_t.pop_front();
                    if (s0 !== es || ot0 !== et) begin
                        errors++; $display("FAIL bp_result got s=%h tag=%h want s=%h tag=%h", s0, ot0, es, et);
                    end
                end
                got++;
            end
            hold = ov0 && !or0; hs = s0; ht = ot0;
        end
        iv0 = 1'b0; or0 = 1'b1;
        checks++; if (got != 20) begin errors++; $display("FAIL bp_count got %0d want 20", got); end
        checks++; if (sent != 20) begin errors++; $display("FAIL bp_sent got %0d want 20", sent); end
    endtask

    task test_reset_midflight;
        or0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            iv0 = 1'b1; a0 = {$urandom, $urandom} | 64'h1; b0 = 64'd7; it0 = 8'(8'h40 + k);
            if (k == 2) rst_n = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1; iv0 = 1'b0;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", ov0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy0); end
        checks++; if (s0 !== 128'd0) begin errors++; $display("FAIL midrst_s got %h want 0", s0); end
        checks++; if (ot0 !== 8'd0) begin errors++; $display("FAIL midrst_tag got %h want 0", ot0); end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ov0 !== 1'b0 || busy0 !== 1'b0) begin
                errors++; $display("FAIL midrst_ghost cycle %0d got v=%b busy=%b want 0 0", k, ov0, busy0);
            end
        end
    endtask

    task automatic soak_one(input int which);
        int           w, acc, got;
        bit           pend, ordy;
        logic [127:0] ra, rb, mask;
        logic [255:0] q_s [$];
        logic [7:0]   q_t [$];
        logic [7:0]   tg, tv, et;
        logic         ir, ov;
        logic [255:0] sv, es;
        w = (which == 0) ? 64 : (which == 1) ? 32 : 128;
        mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        acc = 0; got = 0; pend = 1'b0; tg = 8'd0; ra = '0; rb = '0;
        for (int cyc = 0; cyc < 40000 && got < 10000; cyc++) begin
            @(posedge clk); #1;
            if (!pend && acc < 10000 && $urandom_range(0, 9) < 7) begin
                ra = {$urandom, $urandom, $urandom, $urandom};
                rb = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 15) == 0) ra = '1;
                if ($urandom_range(0, 15) == 0) rb = '1;
                ra = ra & mask; rb = rb & mask; pend = 1'b1;
            end
            ordy = ($urandom_range(0, 9) < 7);
            case (which)
                0:       begin iv0 = pend; a0 = ra[63:0]; b0 = rb[63:0]; it0 = tg; or0 = ordy; end
                1:       begin iv1 = pend; a1 = ra[31:0]; b1 = rb[31:0]; it1 = tg; or1 = ordy; end
                default: begin iv2 = pend; a2 = ra;       b2 = rb;       it2 = tg; or2 = ordy; end
            endcase
            #2;
            case (which)
                0:       begin ir = ir0; ov = ov0; sv = {128'd0, s0}; tv = ot0; end
                1:       begin ir = ir1; ov = ov1; sv = {192'd0, s1}; tv = ot1; end
                default: begin ir = ir2; ov = ov2; sv = s2;           tv = ot2; end
            endcase
            if (pend && ir) begin
                q_s.push_back({128'd0, ra} * {128'd0, rb});
                q_t.push_back(tg);
                tg++; acc++; pend = 1'b0;
            end
            if (ov && ordy) begin
                checks++;
                if (q_s.size() == 0) begin
                    errors++; $display("FAIL soak%0d_unexpected got tag %h want no output", which, tv);
                end else begin
                    es = q_s.pop_front(); et = q_t.pop_front();
                    if (sv !== es || tv !== et) begin
                        errors++;
                        $display("FAIL soak%0d beat %0d got s=%h tag=%h want s=%h tag=%h", which, got, sv, tv, es, et);
                    end
                end
                got++;
            end
        end
        case (which)
            0:       begin iv0 = 1'b0; or0 = 1'b1; end
            1:       begin iv1 = 1'b0; or1 = 1'b1; end
            default: begin iv2 = 1'b0; or2 = 1'b1; end
        endcase
        checks++; if (got != 10000) begin errors++; $display("FAIL soak%0d_count got %0d want 10000", which, got); end
        checks++; if (acc != 10000) begin errors++; $display("FAIL soak%0d_accepted got %0d want 10000", which, acc); end
    endtask

    task test_soak;
        fork
            soak_one(0);
            soak_one(1);
            soak_one(2);
        join
    endtask

    initial begin
        rst_n = 1'b0;
        iv0 = 1'b0; a0 = '0; b0 = '0; it0 = '0; or0 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; it1 = '0; or1 = 1'b1;
        iv2 = 1'b0; a2 = '0; b2 = '0; it2 = '0; or2 = 1'b1;
        test_reset();
        test_latency();
        test_extremes();
        test_backpressure();
        test_reset_midflight();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
